mem_access_stage: RTL and testbench

Memory-access stage between the EX/MEM register and the MEM/WB register. Takes a decoded load/store from EX/MEM and runs a variable-latency request/acknowledge transaction on the data-memory port. It formats load data with byte/half/word extraction and sign/zero extension, and stalls the upstream pipeline until the access completes. Its write-back outputs drive the MEM/WB register inputs directly.

---
 rtl/mem_access_stage.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: runs one req/ack data-memory transaction per
// load/store, formats load data and stalls upstream until the access completes.
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   input  logic [4:0]  rd_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        reg_write_in,
   input  logic [2:0]  funct3_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] read_data_out,
   output logic [4:0]  rd_out,
   output logic [31:0] ALUResult_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic        wb_valid,
   output logic        fault_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e          state_q, state_d;
   logic            req_q, req_d, we_q, we_d, abort_q, abort_d;
   logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]      be_q, be_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            is_mem, legal, f3_ok, aligned;
   logic [3:0]      req_be;
   logic [31:0]     req_wdata, load_fmt;
   logic [7:0]      lane_byte;
   logic [15:0]     lane_half;

   // Access decode: funct3[1:0] is the size (byte/half/word), funct3[2] the unsigned flag.
   always_comb begin
      is_mem = ex_valid & (mem_read_in | mem_write_in);
      f3_ok  = 1'b0;
      case (funct3_in)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = mem_read_in;
         default:                f3_ok = 1'b0;
      endcase
      case (funct3_in[1:0])
         2'b01:   aligned = ~alu_result_in[0];
         2'b10:   aligned = (alu_result_in[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      legal = (mem_read_in ^ mem_write_in) & f3_ok & aligned;

      case (funct3_in[1:0])
         2'b00: begin
            req_be    = 4'b0001 << alu_result_in[1:0];
            req_wdata = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            req_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{store_data_in[15:0]}};
         end
         default: begin
            req_be    = 4'b1111;
            req_wdata = store_data_in;
         end
      endcase
   end

   // Load formatting relies on the upstream holding address and funct3 through DONE.
   always_comb begin
      lane_byte = rdata_q[{alu_result_in[1:0], 3'b000} +: 8];
      lane_half = alu_result_in[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (funct3_in)
         3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
         3'b100:  load_fmt = {24'd0, lane_byte};
         3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
         3'b101:  load_fmt = {16'd0, lane_half};
         default: load_fmt = rdata_q;
      endcase
   end

   // NOTE: every signal gets a default at the top of the block so no path leaves
   // it unassigned; a missing default would infer a latch.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      case (state_q)
         IDLE: begin
            if (is_mem && legal) begin
               state_d = ACCESS;
               req_d   = 1'b1;
               we_d    = mem_write_in;
               addr_d  = {alu_result_in[31:2], 2'b00};
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = '0;
               abort_d = 1'b0;
            end
         end
         ACCESS: begin
            if (dmem_ack) begin
               rdata_d = dmem_rdata;
               req_d   = 1'b0;
               state_d = DONE;
            end else if (TIMEOUT > 0 && cnt_q == CNT_MAX) begin
               req_d   = 1'b0;
               abort_d = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values computed above regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      stall_out      = 1'b0;
      wb_valid       = 1'b0;
      reg_write_out  = 1'b0;
      mem_to_reg_out = 1'b0;
      fault_out      = 1'b0;
      read_data_out  = '0;
      case (state_q)
         IDLE: begin
            if (!is_mem) begin
               wb_valid      = ex_valid;
               reg_write_out = reg_write_in & ex_valid;
            end else if (!legal) begin
               fault_out = 1'b1;
               wb_valid  = 1'b1;
            end else begin
               stall_out = 1'b1;
            end
         end
         ACCESS: stall_out = 1'b1;
         DONE: begin
            wb_valid       = 1'b1;
            mem_to_reg_out = mem_read_in;
            reg_write_out  = reg_write_in & ~abort_q;
            fault_out      = abort_q;
            if (mem_read_in && !abort_q) read_data_out = load_fmt;
         end
         default: ;
      endcase
   end

   assign dmem_req      = req_q;
   assign dmem_we       = we_q;
   assign dmem_addr     = addr_q;
   assign dmem_wdata    = wdata_q;
   assign dmem_be       = be_q;
   assign rd_out        = rd_in;
   assign ALUResult_out = alu_result_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases followed by random loads/stores
// with random ack latency, checked against an arithmetic reference model.
module tb_mem_access_stage;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, mem_read_in, mem_write_in, reg_write_in;
   logic [31:0] alu_result_in, store_data_in, dmem_rdata;
   logic [4:0]  rd_in;
   logic [2:0]  funct3_in;
   logic        dmem_ack;
   logic        stall_out, dmem_req, dmem_we, reg_write_out, mem_to_reg_out, wb_valid, fault_out;
   logic [31:0] dmem_addr, dmem_wdata, read_data_out, ALUResult_out;
   logic [3:0]  dmem_be;
   logic [4:0]  rd_out;

   int vectors = 0;
   int miscompares = 0;

   mem_access_stage #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result_in(alu_result_in),
      .store_data_in(store_data_in), .rd_in(rd_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .funct3_in(funct3_in),
      .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .read_data_out(read_data_out), .rd_out(rd_out), .ALUResult_out(ALUResult_out),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .wb_valid(wb_valid),
      .fault_out(fault_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference load result: shift the addressed bytes down, mask to size, extend.
   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
      int unsigned size = 1 << f3[1:0];
      logic [31:0] mask, val;
      if (size >= 4) return word;
      mask = (32'd1 << (8 * size)) - 32'd1;
      val  = (word >> (8 * (addr % 4))) & mask;
      if (f3[2] == 1'b0 && val[8*size-1]) val = val | ~mask;
      return val;
   endfunction

   // Applies one EX/MEM instruction and follows it to write-back.
   task automatic run_op(input bit v, input bit r, input bit w, input bit rw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input int delay, input logic [31:0] word);
      bit mem_op, legal, acked, aborted;
      int unsigned size;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      ex_valid = v; mem_read_in = r; mem_write_in = w; reg_write_in = rw;
      funct3_in = f3; alu_result_in = addr; store_data_in = sd; rd_in = rd;
      dmem_ack = 1'b0;
      mem_op = v && (r || w);
      size   = 1 << f3[1:0];
      legal  = (r != w) && (r ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2))
               && (addr % size == 0);
      exp_be = 4'(((1 << size) - 1) << (addr % 4));
      exp_wdata = (size == 1) ? sd[7:0] * 32'h0101_0101 :
                  (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
      @(negedge clk);
      check("rd_pass", {27'd0, rd_out}, {27'd0, rd});
      check("alu_pass", ALUResult_out, addr);
      check("req_idle", dmem_req, 0);
      if (!mem_op) begin
         check("np_wb_valid", wb_valid, v);
         check("np_reg_write", reg_write_out, rw && v);
         check("np_stall", stall_out, 0);
         check("np_mem_to_reg", mem_to_reg_out, 0);
         check("np_fault", fault_out, 0);
         dmem_ack = 1'($urandom_range(0, 1));
         tick();
         dmem_ack = 1'b0;
         return;
      end
      if (!legal) begin
         check("ill_fault", fault_out, 1);
         check("ill_wb_valid", wb_valid, 1);
         check("ill_reg_write", reg_write_out, 0);
         check("ill_stall", stall_out, 0);
         tick();
         return;
      end
      check("det_stall", stall_out, 1);
      check("det_wb_valid", wb_valid, 0);
      tick();
      acked = 0;
      aborted = 0;
      for (int k = 0; k < TMO; k++) begin
         if (k == delay) begin
            dmem_ack = 1'b1; dmem_rdata = word; acked = 1;
         end else begin
            dmem_rdata = $urandom;
            if (k == TMO - 1) aborted = 1;
         end
         @(negedge clk);
         check("acc_req", dmem_req, 1);
         check("acc_we", dmem_we, w);
         check("acc_addr", dmem_addr, addr & 32'hFFFF_FFFC);
         check("acc_be", {28'd0, dmem_be}, {28'd0, exp_be});
         if (w) check("acc_wdata", dmem_wdata, exp_wdata);
         check("acc_stall", stall_out, 1);
         check("acc_wb_valid", wb_valid, 0);
         tick();
         dmem_ack = 1'b0;
         if (acked || aborted) break;
      end
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("done_req", dmem_req, 0);
      check("done_stall", stall_out, 0);
      check("done_wb_valid", wb_valid, 1);
      check("done_fault", fault_out, aborted);
      check("done_reg_write", reg_write_out, rw && !aborted);
      check("done_mem_to_reg", mem_to_reg_out, r);
      check("done_rdata", read_data_out, (r && !aborted) ? exp_load(f3, addr, word) : 32'd0);
      tick();
      dmem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      ex_valid = 0; mem_read_in = 0; mem_write_in = 0; reg_write_in = 0;
      alu_result_in = 0; store_data_in = 0; rd_in = 0; funct3_in = 0;
      dmem_ack = 0; dmem_rdata = 0;
      #2;
      check("rst_req", dmem_req, 0);
      check("rst_we", dmem_we, 0);
      check("rst_addr", dmem_addr, 0);
      check("rst_wdata", dmem_wdata, 0);
      check("rst_be", {28'd0, dmem_be}, 0);
      check("rst_stall", stall_out, 0);
      check("rst_wb_valid", wb_valid, 0);
      tick();
      rst = 1'b1;
      tick();

      run_op(1, 0, 0, 1, 3'b000, 32'h0000_1234, 0, 5'd3, 0, 0);
      run_op(1, 1, 0, 1, 3'b000, 32'h0000_0103, 0, 5'd4, 0, 32'h80FF_0000);
      run_op(1, 1, 0, 1, 3'b100, 32'h0000_0103, 0, 5'd4, 0, 32'h80FF_0000);
      run_op(1, 0, 1, 0, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd0, 3, 0);
      run_op(1, 1, 0, 1, 3'b010, 32'h0000_0101, 0, 5'd7, 0, 0);
      run_op(1, 1, 0, 1, 3'b010, 32'h0000_0400, 0, 5'd8, 1000, 32'hDEAD_BEEF);
      run_op(1, 1, 1, 1, 3'b010, 32'h0000_0400, 0, 5'd9, 0, 0);
      run_op(1, 0, 1, 0, 3'b100, 32'h0000_0400, 0, 5'd9, 0, 0);
      run_op(0, 1, 0, 1, 3'b010, 32'h0000_0400, 0, 5'd9, 0, 0);

      // Reset in the middle of an access, then a stray ack afterwards.
      ex_valid = 1; mem_read_in = 1; mem_write_in = 0; reg_write_in = 1;
      funct3_in = 3'b010; alu_result_in = 32'h40;
      tick();
      @(negedge clk);
      check("rst_mid_req_before", dmem_req, 1);
      #1;
      rst = 1'b0;
      ex_valid = 0; mem_read_in = 0;
      #1;
      check("rst_mid_req", dmem_req, 0);
      check("rst_mid_stall", stall_out, 0);
      tick();
      rst = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
      @(negedge clk);
      check("post_rst_req", dmem_req, 0);
      check("post_rst_wb_valid", wb_valid, 0);
      tick();
      dmem_ack = 1'b0;
      @(negedge clk);
      check("post_rst_req2", dmem_req, 0);
      check("post_rst_wb_valid2", wb_valid, 0);
      check("post_rst_stall", stall_out, 0);
      tick();

      for (int i = 0; i < 400; i++) begin
         int unsigned kind = $urandom_range(0, 9);
         bit r = (kind <= 4) || (kind == 9);
         bit w = (kind >= 5);
         logic [31:0] a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_op($urandom_range(0, 7) != 0, r && kind != 0, w, 1'($urandom),
                3'($urandom), a, $urandom, 5'($urandom), $urandom_range(0, TMO + 1), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
